// File: rtl/parity_frame_checker.sv
// Serial frame receiver/checker: start bit, 8 data bits LSB first, parity bit, stop bit.
// Reports the received byte, parity/stop-bit status and a saturating parity-error count.
module parity_frame_checker #(
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_en,
    input  logic       sin,
    output logic [7:0] data,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy,
    output logic [7:0] err_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic        check_q, check_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        perr_q, perr_d;
    logic        ferr_q, ferr_d;
    logic [7:0]  cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            par_q   <= 1'b0;
            check_q <= 1'b0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            cnt_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            check_q <= check_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Everything advances only on a bit strobe; valid is the one exception and
    // drops on its own one cycle after the stop bit was taken.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        check_d = check_q;
        data_d  = data_q;
        valid_d = 1'b0;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        cnt_d   = cnt_q;

        if (bit_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (!sin) begin
                        state_d = ST_DATA;
                        idx_d   = 3'd0;
                        par_d   = 1'b0;
                    end
                end
                ST_DATA: begin
                    shift_d[idx_q] = sin;
                    par_d          = par_q ^ sin;
                    if (idx_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
                ST_PARITY: begin
                    check_d = par_q ^ sin;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    data_d  = shift_q;
                    perr_d  = (check_q != ODD_PARITY);
                    ferr_d  = ~sin;
                    valid_d = 1'b1;
                    if (perr_d && (cnt_q != 8'hFF)) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != ST_IDLE);
    assign err_count  = cnt_q;

endmodule

// File: doc/parity_frame_checker.md
PARITY_FRAME_CHECKER -- requirements
Module: parity_frame_checker

Interface
REQ-001 Parameter: ODD_PARITY, default 0, meaning 0 = even parity (the XOR of the 8 data bits and the parity bit equals 0), 1 = odd parity.
REQ-002 Port: clk  input  1  system clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: bit_en  input  1  bit strobe; sin is sampled only on cycles where bit_en=1.
REQ-005 Port: sin  input  1  serial line; idles high.
REQ-006 Port: data  output  8  last received data byte.
REQ-007 Port: valid  output  1  one-cycle pulse marking frame completion.
REQ-008 Port: parity_err  output  1  parity status of the last frame.
REQ-009 Port: frame_err  output  1  stop-bit status of the last frame.
REQ-010 Port: busy  output  1  high while a frame is in progress.
REQ-011 Port: err_count  output  8  number of parity errors since reset.

Function
REQ-012 Frame format, in sampling order: start bit (0), 8 data bits LSB first, parity bit, stop bit (1); 11 sampled bits in total.
REQ-013 FSM states: IDLE, DATA, PARITY, STOP; a state may change only on a cycle where bit_en=1.
REQ-014 IDLE: sin=0 -> DATA, bit index cleared to 0, running XOR cleared to 0; sin=1 -> stay in IDLE.
REQ-015 DATA: sample sin into shift register position [index] and XOR it into the running parity; index 7 -> PARITY, otherwise index+1.
REQ-016 PARITY: XOR the sampled bit into the running parity, store the result as the computed check -> STOP.
REQ-017 STOP evaluation:
  - data <= assembled byte.
  - parity_err <= (check != ODD_PARITY).
  - frame_err <= (sin == 0).
  - valid pulses on the following cycle.
  - next state is IDLE.
REQ-018 valid is high for exactly one clk cycle per completed frame, on the cycle after the STOP-sampling edge; it does not depend on bit_en being high that cycle.
REQ-019 data, parity_err and frame_err update only at frame completion and hold their values otherwise.
REQ-020 A frame with a frame error is still delivered: valid pulses and data/parity_err are updated.
REQ-021 err_count increments by 1 on each completed frame with parity_err=1 and saturates at 255 (no wrap).
REQ-022 busy = 1 in the DATA, PARITY and STOP states; busy = 0 in IDLE.
REQ-023 After STOP the FSM is in IDLE, so a start bit on the very next bit_en is accepted; back-to-back frames have zero idle gap.
REQ-024 When bit_en=0, no state, index, shift or parity register changes.
REQ-025 Latency: valid asserts 1 clk cycle after the bit_en cycle that samples the stop bit.

Reset
REQ-026 rst=1 at a rising edge: FSM -> IDLE, index=0, running parity=0, data=8'h00, valid=0, parity_err=0, frame_err=0, busy=0, err_count=0.
REQ-027 rst has priority over bit_en; asserting rst mid-frame discards the partial frame with no valid pulse, and reception resumes at the next start bit after rst deasserts.

Verification
REQ-028 Even parity, bit_en=1 every cycle, frame 0, A5 LSB first, parity 0, stop 1 -> valid pulses once; data=8'hA5, parity_err=0, frame_err=0, err_count=0.
REQ-029 Even parity, data 8'h07 with parity bit 0 (4th bit should be 1) -> data=8'h07, parity_err=1, err_count=1; repeat the frame with parity bit 1 -> parity_err=0, err_count stays 1.
REQ-030 Stop bit driven 0 on an otherwise good 8'h3C frame -> valid pulses, data=8'h3C, frame_err=1, parity_err=0.
REQ-031 bit_en=1 only every 4th cycle while sending 8'h81 -> identical results to continuous bit_en; busy stays high throughout; valid is 1 cycle wide.
REQ-032 rst pulsed after the 5th data bit, then a full 8'h5A frame -> no valid for the aborted frame; one valid with data=8'h5A; outputs are at reset values before the second frame.
REQ-033 300 back-to-back frames, each with a parity error -> err_count=255, no wrap; zero-gap framing holds, with 300 valid pulses.
